// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
//
// Downstream stage of the 32x32 signed shift multiplier. Accepts one 64-bit
// signed product per valid/ready handshake and sums N_TERMS of them into a
// saturating 64-bit signed accumulator. The completed sum is presented on a
// valid/ready output handshake. Once that handshake completes, the block
// rearms for the next group.
//
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   prod_i        signed product term
//   prod_valid_i  prod_i holds a term to accept
//   prod_ready_o  block can accept a term this cycle (registered, state-only)
//   clr_i         synchronous abort of the current group, highest priority
//   acc_out_o     registered signed accumulated result
//   acc_valid_o   acc_out_o holds a completed group (registered, state-only)
//   acc_ready_i   consumer takes acc_out_o this cycle
//   ovf_o         sticky saturation flag for the current/held group
//   term_cnt_o    terms accepted in the current group
// ---------------------------------------------------------------------------
module product_accumulator #(
  parameter int unsigned N_TERMS = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      prod_i,
  input  logic             prod_valid_i,
  output logic             prod_ready_o,
  input  logic             clr_i,
  output logic [63:0]      acc_out_o,
  output logic             acc_valid_o,
  input  logic             acc_ready_i,
  output logic             ovf_o,
  output logic [CNT_W-1:0] term_cnt_o
);

  // Elaboration-time parameter sanity checks.
  if (N_TERMS < 1 || N_TERMS > 65535) begin : g_bad_n_terms
    $error("product_accumulator: N_TERMS out of range 1..65535");
  end
  if ((N_TERMS >> CNT_W) != 0) begin : g_bad_cnt_w
    $error("product_accumulator: CNT_W too narrow to hold N_TERMS");
  end

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(N_TERMS - 1);
  localparam logic [63:0]      SatMax  = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0]      SatMin  = 64'h8000_0000_0000_0000;

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  state_e            state_q, state_d;
  logic [63:0]       acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              prod_ready_q, prod_ready_d;
  logic              acc_valid_q, acc_valid_d;

  logic              accept;
  logic              drain;
  logic              last_term;
  logic [63:0]       sum_raw;
  logic              pos_ovf;
  logic              neg_ovf;
  logic [63:0]       sum_sat;

  // Handshake qualifiers. The ready/valid flops are only ever set in
  // StAccum/StHold respectively, so they also encode the state.
  always_comb begin
    accept    = prod_ready_q & prod_valid_i;
    drain     = acc_valid_q & acc_ready_i;
    last_term = (cnt_q == LastCnt);
  end

  // Saturating signed add: overflow only when both operands share a sign
  // and the wrapped result has the opposite sign.
  always_comb begin
    sum_raw = acc_q + prod_i;
    pos_ovf = ~acc_q[63] & ~prod_i[63] &  sum_raw[63];
    neg_ovf =  acc_q[63] &  prod_i[63] & ~sum_raw[63];
    if (pos_ovf) begin
      sum_sat = SatMax;
    end else if (neg_ovf) begin
      sum_sat = SatMin;
    end else begin
      sum_sat = sum_raw;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StAccum;
      acc_q        <= '0;
      ovf_q        <= 1'b0;
      cnt_q        <= '0;
      prod_ready_q <= 1'b0;
      acc_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      ovf_q        <= ovf_d;
      cnt_q        <= cnt_d;
      prod_ready_q <= prod_ready_d;
      acc_valid_q  <= acc_valid_d;
    end
  end

  // Next-state logic. clr_i overrides any simultaneous accept or drain.
  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = StAccum;
    end else begin
      unique case (state_q)
        StAccum: if (accept && last_term) state_d = StHold;
        StHold:  if (drain)               state_d = StAccum;
        default:                          state_d = StAccum;
      endcase
    end
  end

  // Datapath next values.
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      acc_d = '0;
      ovf_d = 1'b0;
      cnt_d = '0;
    end else if (accept) begin
      acc_d = sum_sat;
      ovf_d = ovf_q | pos_ovf | neg_ovf;
      cnt_d = cnt_q + CNT_W'(1);
    end else if (drain) begin
      acc_d = '0;
      ovf_d = 1'b0;
      cnt_d = '0;
    end
  end

  // Output logic. Handshake flags are registered copies of the next state so
  // neither depends combinationally on the partner's valid/ready; ready stays
  // low until the first clock after reset release.
  always_comb begin
    prod_ready_d = (state_d == StAccum);
    acc_valid_d  = (state_d == StHold);
    prod_ready_o = prod_ready_q;
    acc_valid_o  = acc_valid_q;
    acc_out_o    = acc_q;
    ovf_o        = ovf_q;
    term_cnt_o   = cnt_q;
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator. Four instances with N_TERMS of
// 4, 3, 2 and 1 share one clock and reset; each is driven in turn.
module tb_product_accumulator;

  localparam int CW = 16;

  logic          clk;
  logic          rst_n;
  logic [63:0]   prod       [4];
  logic          prod_valid [4];
  logic          prod_ready [4];
  logic          clr        [4];
  logic [63:0]   acc_out    [4];
  logic          acc_valid  [4];
  logic          acc_ready  [4];
  logic          ovf        [4];
  logic [CW-1:0] term_cnt   [4];

  int n_cmp;
  int n_err;

  product_accumulator #(.N_TERMS(4), .CNT_W(CW)) u_n4 (
    .clk(clk), .rst_n(rst_n), .prod_i(prod[0]), .prod_valid_i(prod_valid[0]),
    .prod_ready_o(prod_ready[0]), .clr_i(clr[0]), .acc_out_o(acc_out[0]),
    .acc_valid_o(acc_valid[0]), .acc_ready_i(acc_ready[0]), .ovf_o(ovf[0]),
    .term_cnt_o(term_cnt[0])
  );
  product_accumulator #(.N_TERMS(3), .CNT_W(CW)) u_n3 (
    .clk(clk), .rst_n(rst_n), .prod_i(prod[1]), .prod_valid_i(prod_valid[1]),
    .prod_ready_o(prod_ready[1]), .clr_i(clr[1]), .acc_out_o(acc_out[1]),
    .acc_valid_o(acc_valid[1]), .acc_ready_i(acc_ready[1]), .ovf_o(ovf[1]),
    .term_cnt_o(term_cnt[1])
  );
  product_accumulator #(.N_TERMS(2), .CNT_W(CW)) u_n2 (
    .clk(clk), .rst_n(rst_n), .prod_i(prod[2]), .prod_valid_i(prod_valid[2]),
    .prod_ready_o(prod_ready[2]), .clr_i(clr[2]), .acc_out_o(acc_out[2]),
    .acc_valid_o(acc_valid[2]), .acc_ready_i(acc_ready[2]), .ovf_o(ovf[2]),
    .term_cnt_o(term_cnt[2])
  );
  product_accumulator #(.N_TERMS(1), .CNT_W(CW)) u_n1 (
    .clk(clk), .rst_n(rst_n), .prod_i(prod[3]), .prod_valid_i(prod_valid[3]),
    .prod_ready_o(prod_ready[3]), .clr_i(clr[3]), .acc_out_o(acc_out[3]),
    .acc_valid_o(acc_valid[3]), .acc_ready_i(acc_ready[3]), .ovf_o(ovf[3]),
    .term_cnt_o(term_cnt[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [63:0] v);
    prod[k]       = v;
    prod_valid[k] = 1'b1;
    step();
    prod_valid[k] = 1'b0;
  endtask

  task automatic handshake(input int k);
    acc_ready[k] = 1'b1;
    step();
    acc_ready[k] = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 4; i++) begin
      prod[i]       = '0;
      prod_valid[i] = 1'b0;
      clr[i]        = 1'b0;
      acc_ready[i]  = 1'b0;
    end
    rst_n = 1'b0;

    // Reset state
    #2;
    chk("rst_acc", acc_out[0], 64'd0);
    chk("rst_valid", acc_valid[0], 1'b0);
    chk("rst_ovf", ovf[0], 1'b0);
    chk("rst_cnt", term_cnt[0], 64'd0);
    #10 rst_n = 1'b1;
    #1;
    chk("rst_ready_pre_clk", prod_ready[0], 1'b0);
    step();
    chk("rst_ready_post_clk", prod_ready[0], 1'b1);

    // Basic group, N=4: 5 - 3 + 10 + 100 = 112
    push(0, 64'd5);
    push(0, -64'sd3);
    push(0, 64'd10);
    chk("basic_acc3", acc_out[0], 64'd12);
    chk("basic_cnt3", term_cnt[0], 64'd3);
    chk("basic_valid3", acc_valid[0], 1'b0);
    push(0, 64'd100);
    chk("basic_acc", acc_out[0], 64'd112);
    chk("basic_valid", acc_valid[0], 1'b1);
    chk("basic_ovf", ovf[0], 1'b0);
    chk("basic_cnt", term_cnt[0], 64'd4);

    // Backpressure: prod is ignored while holding
    prod[0]       = 64'd7;
    prod_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_ready", prod_ready[0], 1'b0);
      chk("bp_acc", acc_out[0], 64'd112);
      chk("bp_cnt", term_cnt[0], 64'd4);
    end
    acc_ready[0] = 1'b1;
    step();
    acc_ready[0] = 1'b0;
    chk("bp_drain_acc", acc_out[0], 64'd0);
    chk("bp_drain_valid", acc_valid[0], 1'b0);
    chk("bp_drain_cnt", term_cnt[0], 64'd0);
    chk("bp_drain_ready", prod_ready[0], 1'b1);
    step();
    prod_valid[0] = 1'b0;
    chk("bp_fresh_acc", acc_out[0], 64'd7);
    chk("bp_fresh_cnt", term_cnt[0], 64'd1);

    // clr with the 3rd term of 4: term dropped
    push(0, 64'd7);
    chk("clr_pre_acc", acc_out[0], 64'd14);
    clr[0] = 1'b1;
    push(0, 64'd7);
    clr[0] = 1'b0;
    chk("clr_acc", acc_out[0], 64'd0);
    chk("clr_cnt", term_cnt[0], 64'd0);

    // clr in HOLD together with acc_ready
    for (int i = 0; i < 4; i++) push(0, 64'd1);
    chk("clrh_valid_pre", acc_valid[0], 1'b1);
    chk("clrh_acc_pre", acc_out[0], 64'd4);
    clr[0]       = 1'b1;
    acc_ready[0] = 1'b1;
    step();
    clr[0]       = 1'b0;
    acc_ready[0] = 1'b0;
    chk("clrh_valid", acc_valid[0], 1'b0);
    chk("clrh_ready", prod_ready[0], 1'b1);
    chk("clrh_acc", acc_out[0], 64'd0);

    // Positive saturation with recovery, N=3
    push(1, 64'h7FFF_FFFF_FFFF_FFF0);
    chk("psat_t1", acc_out[1], 64'h7FFF_FFFF_FFFF_FFF0);
    chk("psat_t1_ovf", ovf[1], 1'b0);
    push(1, 64'h20);
    chk("psat_t2", acc_out[1], 64'h7FFF_FFFF_FFFF_FFFF);
    chk("psat_t2_ovf", ovf[1], 1'b1);
    push(1, -64'sh100);
    chk("psat_acc", acc_out[1], 64'h7FFF_FFFF_FFFF_FEFF);
    chk("psat_ovf", ovf[1], 1'b1);
    chk("psat_valid", acc_valid[1], 1'b1);
    handshake(1);
    chk("psat_drain_ovf", ovf[1], 1'b0);

    // Negative saturation, N=2, then a clean group
    push(2, 64'h8000_0000_0000_0001);
    push(2, -64'sd2);
    chk("nsat_acc", acc_out[2], 64'h8000_0000_0000_0000);
    chk("nsat_ovf", ovf[2], 1'b1);
    chk("nsat_valid", acc_valid[2], 1'b1);
    handshake(2);
    push(2, 64'd1);
    push(2, 64'd1);
    chk("nsat_next_acc", acc_out[2], 64'd2);
    chk("nsat_next_ovf", ovf[2], 1'b0);

    // N=1: each term completes a group
    push(3, -64'sd5);
    chk("n1_acc", acc_out[3], 64'hFFFF_FFFF_FFFF_FFFB);
    chk("n1_valid", acc_valid[3], 1'b1);
    chk("n1_cnt", term_cnt[3], 64'd1);
    push(3, 64'd9);
    chk("n1_hold_acc", acc_out[3], 64'hFFFF_FFFF_FFFF_FFFB);
    handshake(3);
    chk("n1_drain_ready", prod_ready[3], 1'b1);

    // Async reset mid-group
    push(0, 64'd2);
    push(0, 64'd2);
    chk("ares_pre_cnt", term_cnt[0], 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("ares_acc", acc_out[0], 64'd0);
    chk("ares_cnt", term_cnt[0], 64'd0);
    chk("ares_ready", prod_ready[0], 1'b0);
    #3 rst_n = 1'b1;
    step();
    chk("ares_ready_post", prod_ready[0], 1'b1);
    for (int i = 0; i < 4; i++) push(0, 64'd1);
    chk("ares_group_acc", acc_out[0], 64'd4);
    chk("ares_group_valid", acc_valid[0], 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
